// File: rtl/spi_shifter_pkg.sv
// Shared constants and shift-state type for the SPI serial data path.
package spi_shifter_pkg;

    localparam int unsigned SPI_MAX_CHAR      = 128;
    localparam int unsigned SPI_CHAR_LEN_BITS = 7;

    typedef enum logic {
        SPI_SH_IDLE  = 1'b0,
        SPI_SH_SHIFT = 1'b1
    } spi_sh_state_t;

endpackage

// File: rtl/spi_shifter.sv
// SPI shift register: serialises the parallel character onto mosi and captures miso into it.
// Optional SPI_SHIFT_DONE_EN adds a one-cycle done pulse after tip falls.
module spi_shifter
    import spi_shifter_pkg::*;
#(
    parameter int unsigned MAX_CHAR = SPI_MAX_CHAR,
    parameter int unsigned LEN_BITS = SPI_CHAR_LEN_BITS
) (
    input  logic                     wb_clk_in,
    input  logic                     wb_rst,
    input  logic [LEN_BITS-1:0]      len,
    input  logic                     lsb,
    input  logic                     tx_negedge,
    input  logic                     rx_negedge,
    input  logic                     go,
    input  logic                     pos_edge,
    input  logic                     neg_edge,
    input  logic [MAX_CHAR/32-1:0]   latch,
    input  logic [31:0]              p_in,
    input  logic                     miso,
    output logic                     tip,
    output logic                     last,
    output logic [MAX_CHAR-1:0]      p_out,
    output logic                     mosi
`ifdef SPI_SHIFT_DONE_EN
    ,
    output logic                     done
`endif
);

    localparam int unsigned CW     = LEN_BITS + 1;
    localparam int unsigned NWORDS = MAX_CHAR / 32;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CHAR);

    spi_sh_state_t        state;
    logic [CW-1:0]        tx_cnt;
    logic [CW-1:0]        rx_cnt;
    logic [CW-1:0]        n_bits;
    logic [LEN_BITS-1:0]  tx_idx;
    logic [LEN_BITS-1:0]  rx_idx;
    logic                 tx_clk;
    logic                 rx_clk;

    // Indices never exceed MAX_CHAR-1, so the top counter bit is dropped.
    always_comb begin
        tx_clk = tx_negedge ? neg_edge : pos_edge;
        rx_clk = rx_negedge ? neg_edge : pos_edge;
        n_bits = (len == '0) ? CNT_MAX : {1'b0, len};
        tx_idx = LEN_BITS'(lsb ? (n_bits - tx_cnt) : (tx_cnt - CNT_ONE));
        rx_idx = LEN_BITS'(lsb ? rx_cnt : (n_bits - CNT_ONE - rx_cnt));
    end

    assign tip  = (state == SPI_SH_SHIFT);
    assign last = (tx_cnt == '0);

    always_ff @(posedge wb_clk_in or posedge wb_rst) begin
        if (wb_rst) begin
            state  <= SPI_SH_IDLE;
            tx_cnt <= '0;
            rx_cnt <= '0;
            mosi   <= 1'b0;
            p_out  <= '0;
`ifdef SPI_SHIFT_DONE_EN
            done   <= 1'b0;
`endif
        end else begin
`ifdef SPI_SHIFT_DONE_EN
            done <= 1'b0;
`endif
            case (state)
                SPI_SH_IDLE: begin
                    for (int unsigned w = 0; w < NWORDS; w++) begin
                        if (latch[w]) begin
                            p_out[32*w +: 32] <= p_in;
                        end
                    end
                    if (go) begin
                        state  <= SPI_SH_SHIFT;
                        tx_cnt <= n_bits;
                        rx_cnt <= '0;
                    end
                end
                SPI_SH_SHIFT: begin
                    // TX reads the pre-edge register even when RX writes on the same edge.
                    if (tx_clk && (tx_cnt != '0)) begin
                        mosi   <= p_out[tx_idx];
                        tx_cnt <= tx_cnt - CNT_ONE;
                    end
                    if (rx_clk) begin
                        p_out[rx_idx] <= miso;
                        rx_cnt        <= rx_cnt + CNT_ONE;
                        if (rx_cnt == (n_bits - CNT_ONE)) begin
                            state <= SPI_SH_IDLE;
`ifdef SPI_SHIFT_DONE_EN
                            done  <= 1'b1;
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shifter.sv
// Randomised bench for spi_shifter against a queue-based transfer model.
module tb_spi_shifter;

    logic         wb_clk_in = 1'b0;
    logic         wb_rst    = 1'b0;
    logic [6:0]   len_r     = '0;
    logic         lsb_r     = 1'b0;
    logic         txn_r     = 1'b0;
    logic         rxn_r     = 1'b0;
    logic         loop_r    = 1'b0;
    logic         go        = 1'b0;
    logic         pos_edge  = 1'b0;
    logic         neg_edge  = 1'b0;
    logic [3:0]   latch     = '0;
    logic [31:0]  p_in      = '0;
    logic         miso_drv  = 1'b0;
    logic         miso;
    logic         tip;
    logic         last;
    logic [127:0] p_out;
    logic         mosi;
`ifdef SPI_SHIFT_DONE_EN
    logic         done;
`endif

    assign miso = loop_r ? mosi : miso_drv;

    always #5 wb_clk_in = ~wb_clk_in;

    spi_shifter #(.MAX_CHAR(128), .LEN_BITS(7)) dut (
        .wb_clk_in  (wb_clk_in),
        .wb_rst     (wb_rst),
        .len        (len_r),
        .lsb        (lsb_r),
        .tx_negedge (txn_r),
        .rx_negedge (rxn_r),
        .go         (go),
        .pos_edge   (pos_edge),
        .neg_edge   (neg_edge),
        .latch      (latch),
        .p_in       (p_in),
        .miso       (miso),
        .tip        (tip),
        .last       (last),
        .p_out      (p_out),
        .mosi       (mosi)
`ifdef SPI_SHIFT_DONE_EN
        ,
        .done       (done)
`endif
    );

    // Reference model: transfer is a list of bit positions consumed in order.
    logic         m_busy = 1'b0;
    logic [127:0] m_data = '0;
    logic         m_mosi = 1'b0;
    logic         m_done = 1'b0;
    int           tx_q[$];
    int           rx_q[$];
    logic [127:0] seq  = '0;
    int           nseq = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic go_i, input logic [3:0] latch_i, input logic [31:0] pin_i,
                        input logic pos_i, input logic neg_i, input logic miso_i);
        logic txc, rxc, mi, nd;
        int   p, nb;
        go = go_i; latch = latch_i; p_in = pin_i;
        pos_edge = pos_i; neg_edge = neg_i; miso_drv = miso_i;
        mi  = loop_r ? m_mosi : miso_i;
        txc = txn_r ? neg_i : pos_i;
        rxc = rxn_r ? neg_i : pos_i;
        nd  = 1'b0;
        if (!m_busy) begin
            for (int w = 0; w < 4; w++)
                if (latch_i[w]) m_data[32*w +: 32] = pin_i;
            if (go_i) begin
                m_busy = 1'b1;
                tx_q.delete();
                rx_q.delete();
                nb = (len_r == 7'd0) ? 128 : int'(len_r);
                for (int k = 0; k < nb; k++) begin
                    p = lsb_r ? k : nb - 1 - k;
                    tx_q.push_back(p);
                    rx_q.push_back(p);
                end
            end
        end else begin
            if (txc && tx_q.size() > 0) begin
                p = tx_q.pop_front();
                m_mosi = m_data[p[6:0]];
                seq = {seq[126:0], m_mosi};
                nseq++;
            end
            if (rxc) begin
                p = rx_q.pop_front();
                m_data[p[6:0]] = mi;
                if (rx_q.size() == 0) begin
                    m_busy = 1'b0;
                    nd = 1'b1;
                end
            end
        end
        m_done = nd;
        @(posedge wb_clk_in);
        #1;
        check("tip", tip, m_busy);
        check("last", last, tx_q.size() == 0);
        check("mosi", mosi, m_mosi);
        check("p_out", p_out, m_data);
`ifdef SPI_SHIFT_DONE_EN
        check("done", done, m_done);
`endif
    endtask

    task automatic do_reset();
        go = 1'b0; latch = '0; pos_edge = 1'b0; neg_edge = 1'b0;
        #2 wb_rst = 1'b1;
        #1;
        m_busy = 1'b0; m_data = '0; m_mosi = 1'b0; m_done = 1'b0;
        tx_q.delete();
        rx_q.delete();
        check("rst_tip", tip, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_pout", p_out, 128'd0);
        check("rst_last", last, 1'b1);
`ifdef SPI_SHIFT_DONE_EN
        check("rst_done", done, 1'b0);
`endif
        @(posedge wb_clk_in);
        #1 wb_rst = 1'b0;
    endtask

    // mmode: 0 = random miso, 1 = miso tied high (ignored when looped back).
    task automatic run_xfer(input logic [6:0] l, input logic lsb_i, input logic txn_i,
                            input logic rxn_i, input logic loop_i, input logic mmode,
                            input logic [127:0] data, input bit disturb, input int abort_at);
        logic ph, mb, dis;
        int   cyc, nstrobe, gap;
        len_r = l; lsb_r = lsb_i; txn_r = txn_i; rxn_r = rxn_i; loop_r = loop_i;
        seq = '0; nseq = 0;
        for (int w = 0; w < 3; w++)
            step(1'b0, 4'b0001 << w, data[32*w +: 32], 1'b0, 1'b0, 1'b0);
        step(1'b1, 4'b1000, data[127:96], 1'b0, 1'b0, 1'b0);
        ph = 1'b0; cyc = 0; nstrobe = 0;
        while (m_busy && cyc < 3000) begin
            gap = $urandom_range(0, 1);
            for (int g = 0; g < gap; g++) begin
                mb = mmode ? 1'b1 : 1'($urandom_range(0, 1));
                step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, mb);
                cyc++;
            end
            mb  = mmode ? 1'b1 : 1'($urandom_range(0, 1));
            dis = disturb && (nstrobe == 5);
            step(dis, dis ? 4'h1 : 4'h0, 32'h12345678, ph, ~ph, mb);
            ph = ~ph;
            nstrobe++;
            cyc++;
            if (abort_at != 0 && nseq == abort_at) begin
                do_reset();
                return;
            end
        end
        if (m_busy) check("xfer_timeout", 1'b1, 1'b0);
        step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [127:0] d;
        @(posedge wb_clk_in);
        #1;
        do_reset();

        d = {$urandom, $urandom, $urandom, $urandom};
        d[7:0] = 8'hA5;
        run_xfer(7'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, d, 1'b0, 0);
        check("t1_low", p_out[7:0], 8'hA5);
        check("t1_seq", seq[7:0], 8'b10100101);
        check("t1_high", p_out[127:8], d[127:8]);

        d = {$urandom, $urandom, $urandom, $urandom};
        d[7:0] = 8'h01;
        run_xfer(7'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, d, 1'b0, 0);
        check("t2_seq", seq[7:0], 8'b10000000);
        check("t2_low", p_out[7:0], 8'hFF);

        d = {4{32'hDEADBEEF}};
        run_xfer(7'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, d, 1'b0, 0);
        check("t3_ntx", nseq, 128);
        check("t3_seq", seq, {4{32'hDEADBEEF}});
        check("t3_pout", p_out, {4{32'hDEADBEEF}});
        check("t3_last", last, 1'b1);

        d = {96'h0, 32'h000000C3};
        run_xfer(7'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, d, 1'b1, 0);
        check("t4_word0", p_out[31:0], 32'h000000C3);
        check("t4_ntx", nseq, 8);

        d = {96'h0, 32'h0000005A};
        run_xfer(7'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, d, 1'b0, 3);
        d = {96'h0, 32'h0000003C};
        run_xfer(7'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, d, 1'b0, 0);
        check("t5_ntx", nseq, 8);
        check("t5_low", p_out[7:0], 8'h3C);

        for (int i = 0; i < 14; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            run_xfer(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'b0, d, bit'($urandom_range(0, 1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
